// File: rtl/cpu_clock_controller.sv
// -----------------------------------------------------------------------------
// cpu_clock_controller
//
// Run-control sequencer that sits between the free-running system clock and
// the RV32I core. The core never gets a gated clock. It qualifies every
// register update with the single-cycle enable `ce` produced here.
//
// Modes: power-on reset stretch (RST_HOLD), HALTED, free RUNNING with a
// programmable enable divider, and single STEPPING. A breakpoint level stops
// a free run.
//
// Parameters
//   DIV_W      width of the divider value `div`
//   RST_CYCLES clk cycles cpu_rst_n stays low after rst_n deasserts (>= 1)
//   START_RUN  1 = go to RUNNING after the reset hold, 0 = go to HALTED
//
// Ports
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   run          pulse: start free running (accepted in HALTED)
//   halt         pulse: stop issuing enables (highest priority)
//   step         pulse: issue exactly one enable, then halt
//   brk          breakpoint level; stops RUNNING
//   div          enable period minus one, sampled on entry to RUNNING/STEPPING
//   ce           registered clock-enable to the core
//   cpu_rst_n    registered active-low reset to the core
//   state        0=RST_HOLD, 1=HALTED, 2=RUNNING, 3=STEPPING
//   cycle_count  number of ce pulses issued (wraps, cleared only by rst_n)
// -----------------------------------------------------------------------------
module cpu_clock_controller #(
  parameter int DIV_W      = 8,
  parameter int RST_CYCLES = 16,
  parameter bit START_RUN  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             halt,
  input  logic             step,
  input  logic             brk,
  input  logic [DIV_W-1:0] div,
  output logic             ce,
  output logic             cpu_rst_n,
  output logic [1:0]       state,
  output logic [31:0]      cycle_count
);

  // Hold counter only needs to reach RST_CYCLES-1.
  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_HALTED   = 2'd1,
    ST_RUNNING  = 2'd2,
    ST_STEPPING = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_ce;
  logic              r_cpu_rst_n;
  logic [31:0]       r_cycle_count;
  logic [HOLD_W-1:0] r_hold;
  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  r_div;

  logic              w_hold_done;
  logic              w_cnt_hit;
  logic [DIV_W-1:0]  w_cnt_inc;
  logic [31:0]       w_count_inc;
  state_t            w_post_hold_state;

  // Combinational helpers shared by the sequencer.
  always_comb begin
    w_hold_done = 1'b0;
    w_cnt_hit   = 1'b0;
    w_cnt_inc   = r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
    w_count_inc = r_cycle_count + 32'd1;
    if (r_hold == HOLD_LAST) begin
      w_hold_done = 1'b1;
    end else begin
      w_hold_done = 1'b0;
    end
    // An enable is due once the divider counter has reached the latched period.
    if (r_cnt == r_div) begin
      w_cnt_hit = 1'b1;
    end else begin
      w_cnt_hit = 1'b0;
    end
    if (START_RUN) begin
      w_post_hold_state = ST_RUNNING;
    end else begin
      w_post_hold_state = ST_HALTED;
    end
  end

  // Run-control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RST_HOLD;
      r_ce          <= 1'b0;
      r_cpu_rst_n   <= 1'b0;
      r_cycle_count <= 32'd0;
      r_hold        <= '0;
      r_cnt         <= '0;
      r_div         <= '0;
    end else begin
      case (r_state)
        // Stretch the core reset. Run-control inputs are ignored here.
        ST_RST_HOLD: begin
          r_ce <= 1'b0;
          if (w_hold_done) begin
            r_cpu_rst_n <= 1'b1;
            r_state     <= w_post_hold_state;
            r_cnt       <= '0;
            r_div       <= div;
          end else begin
            r_hold <= r_hold + {{(HOLD_W-1){1'b0}}, 1'b1};
          end
        end

        // Idle. halt outranks step, step outranks run. A held brk does not
        // block step or run, so the core can step past a breakpoint.
        ST_HALTED: begin
          r_ce <= 1'b0;
          if (halt) begin
            r_state <= ST_HALTED;
          end else if (step) begin
            r_state <= ST_STEPPING;
            r_cnt   <= '0;
            r_div   <= div;
          end else if (run) begin
            r_state <= ST_RUNNING;
            r_cnt   <= '0;
            r_div   <= div;
          end else begin
            r_state <= ST_HALTED;
          end
        end

        // Free run. Enables repeat every r_div+1 cycles. halt/brk stop the
        // run on the sampling edge, with no further enable.
        ST_RUNNING: begin
          if (halt || brk) begin
            r_state <= ST_HALTED;
            r_ce    <= 1'b0;
          end else if (w_cnt_hit) begin
            r_ce          <= 1'b1;
            r_cnt         <= '0;
            r_cycle_count <= w_count_inc;
          end else begin
            r_ce  <= 1'b0;
            r_cnt <= w_cnt_inc;
          end
        end

        // Single step. One enable, then back to HALTED. Only halt cancels it.
        ST_STEPPING: begin
          if (halt) begin
            r_state <= ST_HALTED;
            r_ce    <= 1'b0;
          end else if (w_cnt_hit) begin
            r_ce          <= 1'b1;
            r_state       <= ST_HALTED;
            r_cycle_count <= w_count_inc;
          end else begin
            r_ce  <= 1'b0;
            r_cnt <= w_cnt_inc;
          end
        end

        default: begin
          r_state     <= ST_RST_HOLD;
          r_ce        <= 1'b0;
          r_cpu_rst_n <= 1'b0;
          r_hold      <= '0;
        end
      endcase
    end
  end

  assign ce          = r_ce;
  assign cpu_rst_n   = r_cpu_rst_n;
  assign state       = r_state;
  assign cycle_count = r_cycle_count;

endmodule

// File: doc/cpu_clock_controller.md
Name: cpu_clock_controller

Overview:
- Run-control sequencer between the free-running system clock and the RV32I core.
- Generates a single-cycle clock-enable `ce` that the core datapath and control unit qualify every register update with.
- Provides run, halt, single-step and breakpoint-halt modes, a programmable enable divider, and a power-on reset stretch for the core.
- Sits beside the clock generator at the top level; all core state advances only on `ce`.

Parameters:
- DIV_W, 8, width of divider value `div`.
- RST_CYCLES, 16, clk cycles `cpu_rst_n` stays low after `rst_n` deasserts (≥1).
- START_RUN, 0, 1 = enter RUNNING after reset hold, 0 = enter HALTED.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- run  input  1  one-cycle pulse: start free running.
- halt  input  1  one-cycle pulse: stop issuing enables.
- step  input  1  one-cycle pulse: issue exactly one enable, then halt.
- brk  input  1  breakpoint hit (level); halts while RUNNING.
- div  input  DIV_W  enable period minus one (0 = enable every cycle).
- ce  output  1  registered clock-enable to the core.
- cpu_rst_n  output  1  registered active-low reset to the core.
- state  output  2  0=RST_HOLD, 1=HALTED, 2=RUNNING, 3=STEPPING.
- cycle_count  output  32  count of issued `ce` pulses.

Behaviour:
- Reset (rst_n=0, asynchronous): state=RST_HOLD, ce=0, cpu_rst_n=0, cycle_count=0, hold counter=0, divider counter cnt=0, div_r=0.
- RST_HOLD:
  - Hold counter increments each cycle.
  - At the edge where the counter equals RST_CYCLES-1: cpu_rst_n←1, state←(START_RUN ? RUNNING : HALTED), cnt←0, div_r←div.
  - run/halt/step/brk are ignored in this state.
- All other outputs are registered. Rules per edge, priority halt > brk > step > run:
  - HALTED: ce←0.
    - step → STEPPING.
    - Else run → RUNNING.
    - On either entry: cnt←0, div_r←div (div is sampled only on entry; changes while active are ignored).
  - RUNNING:
    - halt or brk → HALTED, ce←0 (no enable is ever output after the edge that samples halt/brk).
    - Otherwise, if cnt==div_r: ce←1, cnt←0. Else ce←0, cnt←cnt+1.
    - run and step are ignored.
  - STEPPING:
    - halt → HALTED, ce←0 (step cancelled, no enable).
    - Otherwise, if cnt==div_r: ce←1, state←HALTED. Else ce←0, cnt←cnt+1.
    - brk, run and step are ignored.
- Latency:
  - First ce is high in the cycle after the (div_r+1)-th edge following entry.
  - Subsequent ce pulses have a period of div_r+1 cycles.
  - div_r=0 in RUNNING gives ce continuously high.
- ce is never high for more than one cycle when div_r>0. In STEPPING, exactly one ce pulse is produced.
- cycle_count increments on every edge at which ce←1 and wraps from 0xFFFFFFFF to 0. It is cleared only by rst_n.
- brk held high in HALTED: step still works (step past breakpoint); run is accepted, and RUNNING exits on the next edge if brk is still 1 (no ce issued).
- rst_n asserted mid-run or mid-step: immediate return to reset values, including ce=0 and cpu_rst_n=0; the hold sequence restarts.
- state output equals the internal state register.

Test Plan:
- Reset release, RST_CYCLES=16, START_RUN=0 → cpu_rst_n rises after exactly 16 rising edges, state=1, ce stays 0, cycle_count=0.
- HALTED, div=0, run pulse at edge k → ce high continuously from after edge k+1; halt pulse at edge k+10 → ce=0 from after edge k+10, cycle_count=9.
- HALTED, div=3, run → ce one-cycle pulses after edges k+4, k+8, k+12; change div to 0 mid-run → period stays 4.
- HALTED, div=2, step pulse → exactly one ce after edge k+3, state returns to 1, cycle_count+1; step then halt before the enable → zero ce, state=1.
- RUNNING div=0, brk=1 at edge j → no ce after edge j, state=1; step with brk still high → one ce issued.
- Assert rst_n=0 asynchronously mid-RUNNING (between edges) → ce=0, cpu_rst_n=0, state=0, cycle_count=0 immediately; preload cycle_count near 0xFFFFFFFF via a long run → wraps to 0.
